edp_diag_snap: RTL and testbench

Diagnostic snapshot sequencer that sits directly downstream of the EDP EBUS driver. On request it walks the EDP diagnostic read functions 0–7 (AR, BR, MQ, FM, BRX, ARX, ADX, AD) and captures each selected word off the EBUS. It hands each captured word, with its selector and parity, to the front-end console path over a valid/ready handshake. It retries when the EBOX's own AD-to-EBUS traffic pre-empts the diagnostic read.

---
 rtl/edp_pkg.sv | 33 +++
 rtl/edp_diag_snap.sv | 121 ++++++++++++
 tb/tb_edp_diag_snap.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edp_pkg.sv
// edp_pkg: shared types, diag function codes and mask helper for EDP diag blocks
package edp_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, FINISH} tSnapState;

    localparam logic [2:0] DIAG_AR  = 3'd0;
    localparam logic [2:0] DIAG_BR  = 3'd1;
    localparam logic [2:0] DIAG_MQ  = 3'd2;
    localparam logic [2:0] DIAG_FM  = 3'd3;
    localparam logic [2:0] DIAG_BRX = 3'd4;
    localparam logic [2:0] DIAG_ARX = 3'd5;
    localparam logic [2:0] DIAG_ADX = 3'd6;
    localparam logic [2:0] DIAG_AD  = 3'd7;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } tLowest;

    // Index of the lowest selected function; scanning downwards lets the lowest win.
    function automatic tLowest lowest_set(input logic [0:7] mask);
        tLowest r;
        r = '0;
        for (int k = 7; k >= 0; k--) begin
            if (mask[k]) begin
                r.valid = 1'b1;
                r.idx   = 3'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edp_diag_snap.sv
// edp_diag_snap: walks selected EDP diag read functions and hands captured EBUS words to the console
module edp_diag_snap #(
    parameter int RETRY_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:7]  func_mask,
    input  logic        abort,
    output logic        diag_read,
    output logic [4:6]  diag_func,
    input  logic        ebus_drive,
    input  logic [0:35] ebus_data,
    input  logic        ad_to_ebus,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic [0:2]  snap_sel,
    output logic [0:35] snap_data,
    output logic        snap_par,
    output logic        busy,
    output logic        done,
    output logic        err
);
    import edp_pkg::*;

    tSnapState  state;
    logic [0:7] mask;
    logic [0:7] maskLeft;
    logic [2:0] cur;
    logic [3:0] retry;
    logic       issueOk;
    logic       captureOk;
    tLowest     first;
    tLowest     nxt;

    // Mask with the word being presented removed, used to pick the next function.
    always_comb begin
        maskLeft      = mask;
        maskLeft[cur] = 1'b0;
    end

    assign first     = lowest_set(func_mask);
    assign nxt       = lowest_set(maskLeft);
    assign captureOk = issueOk && ebus_drive && !ad_to_ebus;
    assign busy      = state != IDLE;
    assign snap_par  = ^snap_data;

    // Sequencer: the EBUS must be clean in both ISSUE and CAPTURE, otherwise the read is retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask       <= '0;
            cur        <= DIAG_AR;
            retry      <= '0;
            issueOk    <= 1'b0;
            diag_read  <= 1'b0;
            diag_func  <= DIAG_AR;
            snap_valid <= 1'b0;
            snap_sel   <= '0;
            snap_data  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state      <= IDLE;
                diag_read  <= 1'b0;
                snap_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        mask      <= func_mask;
                        err       <= 1'b0;
                        retry     <= '0;
                        cur       <= first.idx;
                        diag_func <= first.idx;
                        diag_read <= first.valid;
                        state     <= first.valid ? ISSUE : FINISH;
                    end
                    ISSUE: begin
                        issueOk <= ebus_drive && !ad_to_ebus;
                        state   <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (captureOk) begin
                            snap_data  <= ebus_data;
                            snap_sel   <= cur;
                            snap_valid <= 1'b1;
                            diag_read  <= 1'b0;
                            state      <= PRESENT;
                        end else begin
                            retry <= retry + 4'd1;
                            if (retry == 4'(RETRY_MAX - 1)) begin
                                err       <= 1'b1;
                                diag_read <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                state <= ISSUE;
                            end
                        end
                    end
                    PRESENT: if (snap_ready) begin
                        snap_valid <= 1'b0;
                        mask       <= maskLeft;
                        retry      <= '0;
                        cur        <= nxt.idx;
                        diag_func  <= nxt.idx;
                        diag_read  <= nxt.valid;
                        state      <= nxt.valid ? ISSUE : FINISH;
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edp_diag_snap.sv
// tb_edp_diag_snap: scoreboard bench for the diag snapshot sequencer with a simple EDP model
module tb_edp_diag_snap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [0:7]  func_mask = '0;
    logic        abort = 1'b0;
    logic        diag_read;
    logic [4:6]  diag_func;
    logic        ebus_drive;
    logic [0:35] ebus_data = '0;
    logic        ad_to_ebus = 1'b0;
    logic        snap_valid;
    logic        snap_ready = 1'b1;
    logic [0:2]  snap_sel;
    logic [0:35] snap_data;
    logic        snap_par;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [2:0]  sel;
        logic [35:0] data;
    } tExp;

    tExp expQ[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  acc = 0;
    int  at = 0;
    logic doneSeen = 1'b0;
    logic drSeen = 1'b0;
    logic svSeen = 1'b0;

    localparam logic [35:0] BASE = 36'o100000000000;

    edp_diag_snap dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func_mask(func_mask), .abort(abort),
        .diag_read(diag_read), .diag_func(diag_func), .ebus_drive(ebus_drive),
        .ebus_data(ebus_data), .ad_to_ebus(ad_to_ebus), .snap_valid(snap_valid),
        .snap_ready(snap_ready), .snap_sel(snap_sel), .snap_data(snap_data),
        .snap_par(snap_par), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // EDP model: driver follows diag_read, mux output registered one edge after the function is applied
    assign ebus_drive = diag_read;
    always @(posedge clk) ebus_data <= BASE + 36'(diag_func);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every accepted word must match the head of the expected queue
    always @(negedge clk) begin
        if (done) doneSeen = 1'b1;
        if (diag_read) drSeen = 1'b1;
        if (snap_valid) svSeen = 1'b1;
        if (rst_n && snap_valid && snap_ready) begin
            if (expQ.size() == 0) begin
                chk("sbUnexpected", 64'(snap_valid & snap_ready), 64'd0);
            end else begin
                tExp e;
                e = expQ.pop_front();
                chk("sel", 64'(snap_sel), 64'(e.sel));
                chk("data", 64'(snap_data), 64'(e.data));
                chk("par", 64'(snap_par), 64'(^e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [0:7] m, input logic push);
        if (push) begin
            for (int k = 0; k < 8; k++) begin
                if (m[k]) expQ.push_back('{sel: 3'(k), data: BASE + 36'(k)});
            end
        end
        func_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = cyc;
    endtask

    task automatic waitDone(input int lim);
        for (int i = 0; i < lim && !done; i++) tick();
        chk("doneTmo", 64'(done), 64'd1);
        at = cyc;
    endtask

    task automatic waitValid(input int lim);
        for (int i = 0; i < lim && !snap_valid; i++) tick();
        chk("validTmo", 64'(snap_valid), 64'd1);
        at = cyc;
    endtask

    task automatic waitIdle(input int lim);
        for (int i = 0; i < lim && busy; i++) tick();
        chk("idleTmo", 64'(busy), 64'd0);
        at = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        #23;
        chk("rstDiagRead", 64'(diag_read), 64'd0);
        chk("rstDiagFunc", 64'(diag_func), 64'd0);
        chk("rstValid", 64'(snap_valid), 64'd0);
        chk("rstSel", 64'(snap_sel), 64'd0);
        chk("rstData", 64'(snap_data), 64'd0);
        chk("rstPar", 64'(snap_par), 64'd0);
        chk("rstBusy", 64'(busy), 64'd0);
        chk("rstDone", 64'(done), 64'd0);
        chk("rstErr", 64'(err), 64'd0);
        rst_n = 1'b1;
        tick();

        // all eight functions, consumer always ready; a stray start mid-run must be ignored
        snap_ready = 1'b1;
        kick(8'hFF, 1'b1);
        chk("busyFF", 64'(busy), 64'd1);
        waitValid(20);
        chk("latFirst", 64'(at - acc), 64'd2);
        func_mask = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(60);
        chk("doneLatFF", 64'(at - acc), 64'd25);
        tick();
        chk("donePulse", 64'(done), 64'd0);
        chk("errFF", 64'(err), 64'd0);
        chk("sbLeftFF", 64'(expQ.size()), 64'd0);

        // functions 2 and 5, consumer stalls on the first word
        snap_ready = 1'b0;
        kick(8'b00100100, 1'b1);
        waitValid(20);
        for (int i = 0; i < 4; i++) begin
            chk("stallValid", 64'(snap_valid), 64'd1);
            chk("stallSel", 64'(snap_sel), 64'd2);
            chk("stallData", 64'(snap_data), 64'(BASE + 36'd2));
            tick();
        end
        snap_ready = 1'b1;
        tick();
        chk("validDrop", 64'(snap_valid), 64'd0);
        waitDone(30);
        chk("sbLeft25", 64'(expQ.size()), 64'd0);
        tick();

        // empty mask: straight to FINISH, no bus activity
        drSeen = 1'b0;
        svSeen = 1'b0;
        kick(8'h00, 1'b0);
        waitDone(10);
        chk("doneLatM0", 64'(at - acc), 64'd1);
        tick();
        chk("drM0", 64'(drSeen), 64'd0);
        chk("svM0", 64'(svSeen), 64'd0);

        // three pre-empted attempts on function 0, then a clean read
        kick(8'b10000000, 1'b1);
        ad_to_ebus = 1'b1;
        while (cyc < acc + 6) tick();
        ad_to_ebus = 1'b0;
        waitValid(30);
        chk("latRetry", 64'(at - acc), 64'd8);
        waitDone(20);
        chk("errRetry", 64'(err), 64'd0);
        chk("sbLeftRetry", 64'(expQ.size()), 64'd0);
        tick();

        // permanent pre-emption exhausts the retry budget
        doneSeen = 1'b0;
        ad_to_ebus = 1'b1;
        kick(8'b10000000, 1'b0);
        waitIdle(60);
        chk("exhaustLat", 64'(at - acc), 64'd30);
        chk("errSet", 64'(err), 64'd1);
        ad_to_ebus = 1'b0;
        tick();
        tick();
        chk("noDoneErr", 64'(doneSeen), 64'd0);

        // abort in CAPTURE of function 3, then a normal run
        doneSeen = 1'b0;
        svSeen = 1'b0;
        kick(8'b00011000, 1'b0);
        chk("errCleared", 64'(err), 64'd0);
        tick();
        chk("abtDrdPre", 64'(diag_read), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abtBusy", 64'(busy), 64'd0);
        chk("abtDrd", 64'(diag_read), 64'd0);
        chk("abtValid", 64'(snap_valid), 64'd0);
        tick();
        tick();
        chk("abtNoDone", 64'(doneSeen), 64'd0);
        chk("abtNoValid", 64'(svSeen), 64'd0);
        kick(8'b00010000, 1'b1);
        waitDone(20);
        chk("sbLeftAbt", 64'(expQ.size()), 64'd0);
        tick();

        // asynchronous reset while a word is being presented
        snap_ready = 1'b0;
        kick(8'b01000000, 1'b0);
        waitValid(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arstValid", 64'(snap_valid), 64'd0);
        chk("arstDrd", 64'(diag_read), 64'd0);
        chk("arstBusy", 64'(busy), 64'd0);
        chk("arstData", 64'(snap_data), 64'd0);
        #2;
        rst_n = 1'b1;
        snap_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
